iir_decim_out: RTL and testbench
================================

IIR_DECIM_OUT -- requirements
Module: iir_decim_out

Interface
REQ-001 SHALL have parameter LOG2_DECIM, default 2, which sets the decimation factor DECIM = 2^LOG2_DECIM (legal range 1..4).
REQ-002 SHALL have parameter FIFO_AW, default 3, which sets the output FIFO depth DEPTH = 2^FIFO_AW (8 entries at default).
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_en, input, 1 bit: din carries a valid filter output sample this cycle.
REQ-006 SHALL have port din, input, 32 bits: filter output y, interpreted as two's-complement signed.
REQ-007 SHALL have port m_valid, output, 1 bit: FIFO head word is available.
REQ-008 SHALL have port m_ready, input, 1 bit: the sink accepts the head word.
REQ-009 SHALL have port m_data, output, 16 bits: FIFO head word (signed).
REQ-010 SHALL have port fifo_level, output, FIFO_AW+1 bits: number of occupied FIFO entries.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag, set when a decimated word is dropped.
REQ-012 SHALL have port clr_ovf, input, 1 bit: synchronous clear of ovf.

Function
REQ-013 SHALL keep a signed accumulator of 32+LOG2_DECIM bits and a sample counter cnt that runs 0..DECIM-1; both advance only on in_en=1.
REQ-014 SHALL, on in_en with cnt<DECIM-1, set acc<=acc+din and cnt<=cnt+1.
REQ-015 SHALL, on in_en with cnt=DECIM-1, form sum=acc+din and mean=sum>>>LOG2_DECIM (arithmetic shift, floor rounding), then set acc<=0 and cnt<=0 on the same edge.
REQ-016 SHALL reduce mean to 16 bits as defined in REQ-026/REQ-027 and push the result into the FIFO on that same edge.
REQ-017 SHALL implement the FIFO as show-ahead: m_data equals the head entry whenever m_valid=1, and m_valid=(fifo_level!=0).
REQ-018 SHALL pop the head entry on each edge where m_valid=1 and m_ready=1.
REQ-019 SHALL give a latency from final-sample edge to m_valid=1 of exactly one clock when the FIFO was empty (m_valid asserts just after that edge).
REQ-020 SHALL drop the push and set ovf=1 when the FIFO is full and no pop occurs on that edge; level and contents are unchanged.
REQ-021 SHALL allow the push when the FIFO is full and a pop occurs on the same edge; level stays DEPTH.
REQ-022 SHALL wrap read and write pointers modulo DEPTH; fifo_level ranges 0..DEPTH.
REQ-023 SHALL never pop when empty: m_ready while m_valid=0 has no effect, even with a simultaneous push.
REQ-024 SHALL clear ovf on clr_ovf=1, except that a new overflow on the same edge takes priority and leaves ovf=1.

Reset
REQ-025 SHALL, while rst_n=0, force acc=0, cnt=0, pointers=0, fifo_level=0, m_valid=0, m_data=0, and ovf=0; an asserted reset mid-block or mid-drain discards the partial sum and all FIFO contents.

Configuration
REQ-026 SHALL, when macro IIR_DECIM_SAT_EN is defined, saturate mean to the range [-32768, 32767] (outputs 0x8000 and 0x7FFF at the limits).
REQ-027 SHALL, when IIR_DECIM_SAT_EN is not defined, truncate mean to its low 16 bits with wrap-around and contain no saturation logic.

Verification
REQ-028 Averaging: DECIM=4, m_ready=1; din 10,20,30,40 on consecutive in_en cycles -> one word m_data=25, with m_valid high for one cycle starting one clock after the 4th sample.
REQ-029 Floor rounding: din -8,-8,-8,-7 -> m_data=0xFFF8 (-8); in_en gaps between samples do not change the result.
REQ-030 Width reduction: four samples of 0x0010_0000 -> 0x7FFF with IIR_DECIM_SAT_EN defined and 0x0000 without it; four samples of 0xFFF0_0000 -> 0x8000 and 0x0000 respectively.
REQ-031 Overflow: m_ready=0, 9 full blocks -> fifo_level=8 and ovf=1; then m_ready=1 drains exactly the first 8 words in order, and clr_ovf=1 clears ovf.
REQ-032 Full with simultaneous pop/push: FIFO full, m_ready=1 on the push edge -> ovf stays 0, fifo_level stays 8, and the new word is last out.
REQ-033 Reset mid-operation: assert rst_n=0 after 2 of 4 samples with 3 words queued -> all outputs are 0 immediately; after release, the next 4 samples 1,1,1,1 -> m_data=1.

Source files
------------

// File: rtl/iir_decim_out.sv
// Decimating mean of IIR filter output (DECIM = 2^LOG2_DECIM samples per word) into a show-ahead FIFO.
// Define IIR_DECIM_SAT_EN to saturate the 16-bit output word; otherwise the mean wraps to its low 16 bits.
module iir_decim_out #(
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned FIFO_AW    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_en,
  input  logic [31:0]          din,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [15:0]          m_data,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  localparam int unsigned AW    = 32 + LOG2_DECIM;
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam logic [LOG2_DECIM-1:0] CNT_MAX    = '1;
  localparam logic [FIFO_AW:0]      LEVEL_FULL = (FIFO_AW+1)'(DEPTH);

  logic signed [AW-1:0]    acc_q, acc_d;
  logic [LOG2_DECIM-1:0]   cnt_q, cnt_d;
  logic [FIFO_AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]        level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic [15:0]             mem_q [DEPTH];

  logic signed [AW-1:0]    sum;
  logic signed [AW-1:0]    mean;
  logic [15:0]             word;
  logic                    last, full, pop, push, drop;

  always_comb begin
    sum  = acc_q + {{LOG2_DECIM{din[31]}}, din};
    mean = sum >>> LOG2_DECIM;
  end

`ifdef IIR_DECIM_SAT_EN
  // The mean fits in 16 bits only when every bit above bit 15 copies the sign.
  always_comb begin
    if (mean[AW-1:15] != {(AW-15){mean[AW-1]}}) begin
      word = mean[AW-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      word = mean[15:0];
    end
  end
`else
  logic unused_mean_hi;
  assign unused_mean_hi = ^mean[AW-1:16];
  assign word = mean[15:0];
`endif

  always_comb begin
    last    = in_en && (cnt_q == CNT_MAX);
    full    = (level_q == LEVEL_FULL);
    m_valid = (level_q != '0);
    pop     = m_valid && m_ready;
    // A full FIFO still accepts the word when the head leaves on the same edge.
    push    = last && (!full || pop);
    drop    = last && full && !pop;

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (in_en) begin
      acc_d = last ? '0 : sum;
      cnt_d = last ? '0 : cnt_q + LOG2_DECIM'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase

    ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  // Storage is not reset; gating by m_valid keeps m_data at zero while empty.
  assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_iir_decim_out.sv
// Self-checking bench for iir_decim_out: directed scenarios plus random traffic against a queue-based model.
module tb_iir_decim_out;

  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_en = 1'b0;
  logic [31:0] din = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [3:0]  fifo_level;
  logic        ovf;
  logic        clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] q[$];
  longint      m_acc = 0;
  int          m_cnt = 0;
  bit          m_ovf = 1'b0;

  iir_decim_out #(.LOG2_DECIM(2), .FIFO_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .din(din),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fifo_level(fifo_level), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] reduce(input longint s);
    longint m;
    m = s / DECIM;
    if ((s % DECIM) != 0 && s < 0) m = m - 1;
`ifdef IIR_DECIM_SAT_EN
    if (m > 32767)  return 16'h7FFF;
    if (m < -32768) return 16'h8000;
`endif
    return m[15:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".level"}, 32'(fifo_level), 32'(q.size()));
    chk({tag, ".valid"}, 32'(m_valid), 32'(q.size() != 0));
    chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    if (q.size() != 0) chk({tag, ".data"}, 32'(m_data), 32'(q[0]));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input bit en, input logic [31:0] d, input bit rdy, input bit clr, input string tag);
    bit pop, push, dropped;
    logic [15:0] w;
    in_en = en; din = d; m_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    pop = (q.size() != 0) && rdy;
    push = 1'b0;
    dropped = 1'b0;
    w = '0;
    if (en) begin
      m_acc = m_acc + longint'($signed(d));
      m_cnt = m_cnt + 1;
      if (m_cnt == DECIM) begin
        w = reduce(m_acc);
        push = 1'b1;
        m_acc = 0;
        m_cnt = 0;
      end
    end
    if (push && q.size() == DEPTH && !pop) dropped = 1'b1;
    if (pop) void'(q.pop_front());
    if (push && !dropped) q.push_back(w);
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    #1;
    check_outputs(tag);
  endtask

  task automatic rand_block(input bit rdy, input string tag);
    for (int i = 0; i < DECIM; i++) step(1'b1, $urandom, rdy, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    #12;
    chk("rst.level", 32'(fifo_level), 0);
    chk("rst.valid", 32'(m_valid), 0);
    chk("rst.data",  32'(m_data), 0);
    chk("rst.ovf",   32'(ovf), 0);
    @(negedge clk); rst_n = 1'b1;

    // Averaging of 10,20,30,40
    step(1, 32'd10, 1, 0, "avg"); step(1, 32'd20, 1, 0, "avg");
    step(1, 32'd30, 1, 0, "avg"); step(1, 32'd40, 1, 0, "avg");
    chk("avg.valid1", 32'(m_valid), 1);
    chk("avg.data", 32'(m_data), 25);
    step(0, '0, 1, 0, "avg.pop");
    chk("avg.valid0", 32'(m_valid), 0);

    // Floor rounding with gaps between samples
    step(1, -32'sd8, 0, 0, "floor"); step(0, '0, 0, 0, "floor");
    step(1, -32'sd8, 0, 0, "floor"); step(1, -32'sd8, 0, 0, "floor");
    step(0, '0, 0, 0, "floor");      step(1, -32'sd7, 0, 0, "floor");
    chk("floor.data", 32'(m_data), 32'h0000_FFF8);
    step(0, '0, 1, 0, "floor.pop");

    // Width reduction at both limits
    for (int i = 0; i < 4; i++) step(1, 32'h0010_0000, 0, 0, "wpos");
`ifdef IIR_DECIM_SAT_EN
    chk("wpos.data", 32'(m_data), 32'h7FFF);
`else
    chk("wpos.data", 32'(m_data), 32'h0000);
`endif
    step(0, '0, 1, 0, "wpos.pop");
    for (int i = 0; i < 4; i++) step(1, 32'hFFF0_0000, 0, 0, "wneg");
`ifdef IIR_DECIM_SAT_EN
    chk("wneg.data", 32'(m_data), 32'h8000);
`else
    chk("wneg.data", 32'(m_data), 32'h0000);
`endif
    step(0, '0, 1, 0, "wneg.pop");

    // Overflow: nine blocks with sink stalled, then drain and clear
    for (int b = 0; b < 9; b++) rand_block(1'b0, "ovf.fill");
    chk("ovf.level8", 32'(fifo_level), 8);
    chk("ovf.flag", 32'(ovf), 1);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0, "ovf.drain");
    chk("ovf.empty", 32'(fifo_level), 0);
    chk("ovf.sticky", 32'(ovf), 1);
    step(0, '0, 0, 1, "ovf.clr");
    chk("ovf.cleared", 32'(ovf), 0);

    // Full FIFO with simultaneous pop and push
    for (int b = 0; b < 8; b++) rand_block(1'b0, "fp.fill");
    for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, "fp.part");
    d = 32'd4000;
    step(1, d, 1, 0, "fp.push");
    chk("fp.level", 32'(fifo_level), 8);
    chk("fp.ovf", 32'(ovf), 0);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0, "fp.drain");

    // Asynchronous reset mid-block with words queued
    for (int b = 0; b < 3; b++) rand_block(1'b0, "mr.fill");
    step(1, $urandom, 0, 0, "mr.part"); step(1, $urandom, 0, 0, "mr.part");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mr.level", 32'(fifo_level), 0);
    chk("mr.valid", 32'(m_valid), 0);
    chk("mr.data", 32'(m_data), 0);
    chk("mr.ovf", 32'(ovf), 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 32'd1, 0, 0, "mr.after");
    chk("mr.data1", 32'(m_data), 1);
    step(0, '0, 1, 0, "mr.pop");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) d = $urandom;
      else d = 32'($urandom_range(0, 131071)) - 32'd65536;
      step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
